// File: rtl/rom_burst_reader_if.sv
// Command, ROM-side and output-stream signals of rom_burst_reader.
// Optional feature macro: ROM_READER_CHECKSUM_EN adds the checksum signal.
interface rom_burst_reader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport master (
    input  start, start_addr, len, rom_data, out_ready,
`ifdef ROM_READER_CHECKSUM_EN
    output checksum,
`endif
    output busy, done, rom_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, start_addr, len, rom_data, out_ready,
`ifdef ROM_READER_CHECKSUM_EN
    input  checksum,
`endif
    input  busy, done, rom_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst read master for a synchronous ROM: issues sequential addresses, buffers words in a
// 4-entry FIFO under credit control and streams them out. Optional macro: ROM_READER_CHECKSUM_EN.
module rom_burst_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  rom_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [2:0]        outst_q, outst_d;
  logic              busy_q, done_q;

  logic              vld_p0, vld_p1;
  logic              last_p0, last_p1;

  logic [DATA_W-1:0] buf_data [4];
  logic [3:0]        buf_last;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q, cnt_d;

  logic              start_ok, issue, issue_last, push, pop, out_valid, drain_exit;
  logic [ADDR_W-1:0] addr_base;
  logic [ADDR_W:0]   rem_base;

  always_comb begin
    start_ok   = (state_q == IDLE) && bus.start;
    issue      = (start_ok && (bus.len != '0)) || ((state_q == RUN) && (outst_q < 3'd4));
    addr_base  = start_ok ? bus.start_addr : addr_q;
    rem_base   = start_ok ? bus.len : rem_q;
    issue_last = (rem_base == (ADDR_W+1)'(1));
    out_valid  = (cnt_q != 3'd0);
    push       = vld_p1;
    pop        = out_valid && bus.out_ready;
    cnt_d      = cnt_q + 3'(push) - 3'(pop);
    outst_d    = outst_q + 3'(issue) - 3'(pop);
    // Leave DRAIN on the edge that empties the buffer, so done lines up one edge after the last beat.
    drain_exit = !vld_p0 && !vld_p1 && ((cnt_q == 3'd0) || ((cnt_q == 3'd1) && pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      rem_q      <= '0;
      outst_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      last_p0    <= 1'b0;
      last_p1    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      // Issue stage -> ROM register stage -> buffer write
      vld_p0  <= issue;
      last_p0 <= issue && issue_last;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (issue) begin
        rom_addr_q <= addr_base;
        addr_q     <= addr_base + ADDR_W'(1);
        rem_q      <= rem_base - (ADDR_W+1)'(1);
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          busy_q  <= 1'b1;
          // Zero-length and single-word bursts have nothing further to issue.
          state_q <= (bus.len > (ADDR_W+1)'(1)) ? RUN : DRAIN;
        end
        RUN: if (issue && issue_last) state_q <= DRAIN;
        DRAIN: if (drain_exit) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= bus.rom_data;
      buf_last[wr_ptr_q] <= last_p1;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? buf_data[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid && buf_last[rd_ptr_q];

`ifdef ROM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (pop)      csum_q <= csum_q ^ bus.out_data;
  end

  assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader: a ROM model, randomized ready and bursts,
// a queue of expected beats filled at command time and drained by a stream monitor.
module tb_rom_burst_reader;
  localparam int AW = 7;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   beats = 0;
  bit   rdy_mode = 1'b0;
  logic [DW-1:0] rom_mem [128];
  beat_t exp_q[$];

  rom_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: pops the expected beat on each transfer, checks stall stability and buffer overflow.
  initial begin
    bit            stall = 1'b0;
    logic [DW-1:0] stall_d = '0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, stall_d);
        end
        if (dut.push && !dut.pop && dut.cnt_q == 3'd4) begin
          total++;
          bad++;
          $display("FAIL overflow: push while buffer full (t=%0t)", $time);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got data %0d with no beat expected", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", bus.out_data, e.d);
            chk("beat_last", bus.out_last, e.l);
            beats++;
          end
        end
        stall   = bus.out_valid && !bus.out_ready;
        stall_d = bus.out_data;
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
`ifdef ROM_READER_CHECKSUM_EN
    chk("rst_checksum", bus.checksum, 0);
`endif
  endtask

  task automatic run_burst(input int addr, input int n, input bit rnd, input int poke);
    int            done_at;
    int            ndone;
    logic [DW-1:0] acc;
    beat_t         b;
    rdy_mode = rnd;
    acc      = '0;
    for (int i = 0; i < n; i++) begin
      b.d = rom_mem[(addr + i) % 128];
      b.l = (i == n - 1);
      exp_q.push_back(b);
      acc ^= b.d;
    end
    bus.start_addr = AW'(addr);
    bus.len        = (AW+1)'(n);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    done_at = -1;
    ndone   = 0;
    for (int k = 1; k <= 4000; k++) begin
      if (k == poke) begin
        bus.start      = 1'b1;
        bus.start_addr = AW'(50);
        bus.len        = (AW+1)'(5);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          chk("busy_at_done", bus.busy, 1);
          chk("all_beats_at_done", exp_q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
          chk("checksum_at_done", bus.checksum, acc);
`endif
        end
      end
      if (done_at >= 0 && k == done_at + 1) begin
        chk("done_one_cycle", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("checksum_hold", bus.checksum, acc);
`endif
        break;
      end
    end
    bus.start = 1'b0;
    if (done_at < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done for burst addr=%0d len=%0d", addr, n);
    end else if (!rnd) begin
      chk("done_time", done_at, (n == 0) ? 1 : n + 2);
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("done_count", ndone, 1);
  endtask

  initial begin
    int base;
    beat_t b;
    for (int i = 0; i < 128; i++) rom_mem[i] = DW'($urandom);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.len        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    run_burst(0, 128, 1'b0, 0);
    run_burst(33, 20, 1'b1, 0);
    run_burst(120, 16, 1'b0, 0);
    run_burst(7, 0, 1'b0, 0);
    run_burst(99, 1, 1'b0, 0);
    run_burst(10, 30, 1'b0, 8);

    // Reset after five beats of a longer burst, then confirm a fresh burst works.
    rdy_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b.d = rom_mem[(60 + i) % 128];
      b.l = (i == 39);
      exp_q.push_back(b);
    end
    bus.start_addr = AW'(60);
    bus.len        = (AW+1)'(40);
    bus.start      = 1'b1;
    base           = beats;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 200 && beats < base + 5; k++) @(posedge clk);
    #1;
    if (beats < base + 5) begin
      total++;
      bad++;
      $display("FAIL midburst_timeout: saw %0d beats, needed 5", beats - base);
    end
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_burst(100, 12, 1'b0, 0);

    for (int r = 0; r < 6; r++)
      run_burst($urandom_range(0, 127), $urandom_range(1, 40), r[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
